mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single memory port of the pipelined CPU between the IF stage (instruction fetch) and the MEM stage (data load/store). It runs a fixed-latency access state machine and returns fetched or loaded words together with a one-cycle valid pulse. It also generates the stall signals that hold the pipeline registers, including MEM_WB, while an access is outstanding. Data accesses win over fetches, so the older instruction always makes progress.

## Interface
Parameters:
- WORD_SIZE, 16, data and address width
- MEM_LATENCY, 2, cycles the memory needs per access; legal range 1..15

Ports:
- clk  in  1  system clock, rising edge active
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- if_req  in  1  IF stage requests an instruction read
- if_addr  in  WORD_SIZE  fetch address (PC)
- d_read_req  in  1  MEM stage load request
- d_write_req  in  1  MEM stage store request
- d_addr  in  WORD_SIZE  data address
- d_wdata  in  WORD_SIZE  store data
- mem_rdata  in  WORD_SIZE  read data from memory, valid on the last access cycle
- mem_readM  out  1  memory read strobe
- mem_writeM  out  1  memory write strobe
- mem_address  out  WORD_SIZE  memory address
- mem_wdata  out  WORD_SIZE  memory write data
- if_data  out  WORD_SIZE  fetched instruction
- if_valid  out  1  one-cycle pulse: if_data is valid
- d_rdata  out  WORD_SIZE  loaded word
- d_valid  out  1  one-cycle pulse: data access complete (load or store)
- if_stall  out  1  combinational: if_req & ~if_valid
- d_stall  out  1  combinational: (d_read_req | d_write_req) & ~d_valid

## Operation
- States: IDLE, BUSY_I, BUSY_D. There is a down-counter cnt of 4 bits.
- IDLE, at a rising edge:
  - Data request present and d_valid low: go to BUSY_D.
  - Otherwise, if_req high and if_valid low: go to BUSY_I.
  - Otherwise stay in IDLE.
- Data priority: if both requests are pending, the data request is granted and the fetch waits.
- Grant actions (same edge):
  - Latch the address into mem_address. For a store, also latch d_wdata into mem_wdata.
  - Set mem_readM (load or fetch) or mem_writeM (store).
  - Load cnt = MEM_LATENCY-1.
- If d_read_req and d_write_req are both high, the access is a store.
- BUSY_x, at an edge with cnt != 0: decrement cnt. Strobes, address and write data hold.
- BUSY_x, at an edge with cnt == 0 (completion):
  - For a load or fetch, capture mem_rdata into d_rdata or if_data.
  - Pulse the matching valid for the following cycle. A store pulses d_valid only and leaves d_rdata unchanged.
  - Clear mem_readM and mem_writeM, then go to IDLE.
- A requester whose valid is high in the current cycle is not re-granted in that cycle, even if its request is still asserted. That cycle is the pipeline advance cycle.
- Input address and data changes during BUSY are ignored; the latched values drive memory.
- if_data and d_rdata hold their last captured value until the next completion of the same type.
- If a request drops mid-access, the access still runs to completion and pulses valid.

## Timing
- Reset values, applied immediately when reset_n falls:
  - state IDLE, cnt 0
  - mem_readM 0, mem_writeM 0, mem_address 0, mem_wdata 0
  - if_data 0, d_rdata 0, if_valid 0, d_valid 0
- Reset mid-access abandons the access. No valid pulse is produced and strobes drop asynchronously.
- A request sampled at edge E0 in IDLE:
  - Strobes are high from E0 through E(MEM_LATENCY).
  - Valid is high for the single cycle after E(MEM_LATENCY).
  - Next grant no earlier than E(MEM_LATENCY+1).
- Back-to-back accesses leave one IDLE cycle (the valid cycle) between them. Occupancy per access is MEM_LATENCY+1 cycles.
- MEM_LATENCY = 1: strobe is high for exactly one cycle and valid follows in the next cycle.
- Stalls are combinational from the request inputs and registered valids, so they drop in the valid cycle itself.

## Test plan
- **Single fetch, MEM_LATENCY=2:**
  - Stimulus: if_req=1, if_addr=0x0010, memory returns 0x6A01.
  - Required: mem_readM high for 2 cycles with mem_address=0x0010; if_valid pulses 1 cycle with if_data=0x6A01; if_stall high until the valid cycle.
- **Simultaneous requests:**
  - Stimulus: if_req and d_read_req both high (d_addr=0x0080, data 0x1234).
  - Required: data access first and d_valid with d_rdata=0x1234; then the fetch is granted in the cycle after d_valid and completes 3 cycles later; if_stall high throughout.
- **Store:**
  - Stimulus: d_write_req=1, d_addr=0x0040, d_wdata=0xBEEF.
  - Required: mem_writeM high for 2 cycles with mem_wdata=0xBEEF; d_valid pulses; d_rdata unchanged; mem_readM stays 0.
- **Back-to-back fetches, request held high:**
  - Stimulus: addresses 0x0000 then 0x0001, with the address changing during BUSY.
  - Required: address changes during BUSY are ignored; two accesses with exactly one IDLE cycle between; no duplicate grant in the valid cycle.
- **Reset mid-access:**
  - Stimulus: assert reset_n=0 one cycle into a load.
  - Required: strobes, valids and all registered outputs go to 0 immediately; after release the arbiter is in IDLE and re-grants the still-pending load with full latency.
- **Conflicting strobes, MEM_LATENCY=1:**
  - Stimulus: d_read_req and d_write_req both high.
  - Required: a single-cycle store (mem_writeM only); d_valid in the next cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Fixed-latency access FSM; data requests win; valid pulses and stalls for the pipeline.
module mem_port_arbiter #(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  input  logic                 d_read_req,
  input  logic                 d_write_req,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 mem_readM,
  output logic                 mem_writeM,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic [WORD_SIZE-1:0] if_data,
  output logic                 if_valid,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_valid,
  output logic                 if_stall,
  output logic                 d_stall
);

  localparam int unsigned      CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic [WORD_SIZE-1:0] if_data_q, if_data_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic                 if_valid_q, if_valid_d;
  logic                 d_valid_q, d_valid_d;
  logic                 d_req;

  assign d_req = d_read_req | d_write_req;

  // Grant, count down, complete; a requester in its valid cycle is never re-granted.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_data_d   = if_data_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_req && !d_valid_q) begin
          state_d    = BUSY_D;
          cnt_d      = CNT_LOAD;
          mem_addr_d = d_addr;
          if (d_write_req) begin
            mem_write_d = 1'b1;
            mem_wdata_d = d_wdata;
          end else begin
            mem_read_d = 1'b1;
          end
        end else if (if_req && !if_valid_q) begin
          state_d    = BUSY_I;
          cnt_d      = CNT_LOAD;
          mem_addr_d = if_addr;
          mem_read_d = 1'b1;
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (state_q == BUSY_I) begin
            if_data_d  = mem_rdata;
            if_valid_d = 1'b1;
          end else begin
            // Stores leave the last loaded word untouched.
            if (!mem_write_q) d_rdata_d = mem_rdata;
            d_valid_d = 1'b1;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_data_q   <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_data_q   <= if_data_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
    end
  end

  assign mem_readM   = mem_read_q;
  assign mem_writeM  = mem_write_q;
  assign mem_address = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign if_data     = if_data_q;
  assign if_valid    = if_valid_q;
  assign d_rdata     = d_rdata_q;
  assign d_valid     = d_valid_q;

  // Stalls drop in the valid cycle so the pipeline advances there.
  assign if_stall = if_req & ~if_valid_q;
  assign d_stall  = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter at MEM_LATENCY 2 and 1, with a latency-aware memory model.
// Grants are predicted from the priority rules; completions are popped from expected queues.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic [1:0]  kind;   // 0 load, 1 store, 2 load+store (acts as store)
    logic [15:0] addr;
    logic [15:0] wdata;
  } d_item_t;

  logic clk;
  int   n_checks = 0;
  int   n_fails  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] init_val(input logic [7:0] a);
    case (a)
      8'h10:   return 16'h6A01;
      8'h80:   return 16'h1234;
      default: return {a ^ 8'hC3, ~a};
    endcase
  endfunction

  task automatic check(input int lat, input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL L=%0d %s: got %h expected %h at %0t", lat, nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input int lat, input string nm);
    n_checks++;
    n_fails++;
    $display("FAIL L=%0d %s at %0t", lat, nm, $time);
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int unsigned LAT = (g == 0) ? 2 : 1;

    logic        reset_n, if_req, d_read_req, d_write_req;
    logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        mem_readM, mem_writeM, if_valid, d_valid, if_stall, d_stall;
    logic [15:0] mem_address, mem_wdata, if_data, d_rdata;
    bit          done = 1'b0;

    mem_port_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr),
      .d_read_req(d_read_req), .d_write_req(d_write_req),
      .d_addr(d_addr), .d_wdata(d_wdata), .mem_rdata(mem_rdata),
      .mem_readM(mem_readM), .mem_writeM(mem_writeM),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .if_data(if_data), .if_valid(if_valid),
      .d_rdata(d_rdata), .d_valid(d_valid),
      .if_stall(if_stall), .d_stall(d_stall)
    );

    // Memory: real data only on the last strobe cycle, complemented garbage before that.
    logic [15:0] phys [256];
    int unsigned age;
    assign mem_rdata = (age == LAT) ? phys[mem_address[7:0]] : ~phys[mem_address[7:0]];

    initial begin
      for (int i = 0; i < 256; i++) phys[i] = init_val(8'(i));
      age = 0;
      forever begin
        @(negedge clk);
        if (!reset_n || !(mem_readM | mem_writeM)) age = 0;
        else age = age + 1;
        if (reset_n && mem_writeM) phys[mem_address[7:0]] = mem_wdata;
      end
    end

    // Monitor and scoreboard
    logic [15:0] ref_mem [256];
    logic [15:0] if_q [$];
    logic [16:0] d_q [$];
    logic        m_busy, ended, prev_busy, prev_pend_d, prev_pend_i, prev_dwr, acc_is_d, acc_wr;
    logic [15:0] prev_daddr, prev_dwdata, prev_iaddr, acc_addr, acc_wdata, exp_if, exp_d;
    logic [16:0] d_e;
    int unsigned acc_len;

    initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
      prev_busy = 1'b0; prev_pend_d = 1'b0; prev_pend_i = 1'b0; prev_dwr = 1'b0;
      prev_daddr = '0; prev_dwdata = '0; prev_iaddr = '0;
      acc_is_d = 1'b0; acc_wr = 1'b0; acc_addr = '0; acc_wdata = '0; acc_len = 0;
      exp_if = '0; exp_d = '0;
      forever begin
        @(negedge clk);
        m_busy = mem_readM | mem_writeM;
        ended  = 1'b0;
        if (!reset_n) begin
          check(LAT, "rst_readM", 16'(mem_readM), 16'h0);
          check(LAT, "rst_writeM", 16'(mem_writeM), 16'h0);
          check(LAT, "rst_address", mem_address, 16'h0);
          check(LAT, "rst_wdata", mem_wdata, 16'h0);
          check(LAT, "rst_if_data", if_data, 16'h0);
          check(LAT, "rst_d_rdata", d_rdata, 16'h0);
          check(LAT, "rst_valids", 16'({if_valid, d_valid}), 16'h0);
          if_q.delete();
          d_q.delete();
          exp_if = '0; exp_d = '0; prev_busy = 1'b0; acc_len = 0;
        end else begin
          check(LAT, "if_stall", 16'(if_stall), 16'(if_req & ~if_valid));
          check(LAT, "d_stall", 16'(d_stall), 16'((d_read_req | d_write_req) & ~d_valid));
          check(LAT, "strobe_excl", 16'(mem_readM & mem_writeM), 16'h0);
          if (!prev_busy) begin
            if (prev_pend_d || prev_pend_i) begin
              // Data wins whenever it is pending at the grant edge.
              acc_is_d  = prev_pend_d;
              acc_wr    = prev_pend_d && prev_dwr;
              acc_addr  = prev_pend_d ? prev_daddr : prev_iaddr;
              acc_wdata = prev_dwdata;
              acc_len   = 1;
              check(LAT, "grant_readM", 16'(mem_readM), 16'(!acc_wr));
              check(LAT, "grant_writeM", 16'(mem_writeM), 16'(acc_wr));
              check(LAT, "grant_addr", mem_address, acc_addr);
              if (acc_wr) check(LAT, "grant_wdata", mem_wdata, acc_wdata);
              if (!acc_is_d) begin
                if_q.push_back(ref_mem[acc_addr[7:0]]);
              end else if (acc_wr) begin
                ref_mem[acc_addr[7:0]] = acc_wdata;
                d_q.push_back({1'b1, 16'h0});
              end else begin
                d_q.push_back({1'b0, ref_mem[acc_addr[7:0]]});
              end
            end else begin
              check(LAT, "no_grant", 16'(m_busy), 16'h0);
            end
          end else if (m_busy) begin
            acc_len++;
            check(LAT, "hold_addr", mem_address, acc_addr);
            check(LAT, "hold_strobes", 16'({mem_readM, mem_writeM}), 16'({!acc_wr, acc_wr}));
            if (acc_wr) check(LAT, "hold_wdata", mem_wdata, acc_wdata);
          end else begin
            ended = 1'b1;
            check(LAT, "strobe_len", 16'(acc_len), 16'(LAT));
          end
          check(LAT, "if_valid", 16'(if_valid), 16'(ended && !acc_is_d));
          check(LAT, "d_valid", 16'(d_valid), 16'(ended && acc_is_d));
          if (if_valid) begin
            if (if_q.size() == 0) fail_now(LAT, "if_valid_unexpected");
            else exp_if = if_q.pop_front();
          end
          if (d_valid) begin
            if (d_q.size() == 0) fail_now(LAT, "d_valid_unexpected");
            else begin
              d_e = d_q.pop_front();
              if (!d_e[16]) exp_d = d_e[15:0];
            end
          end
          check(LAT, "if_data", if_data, exp_if);
          check(LAT, "d_rdata", d_rdata, exp_d);
          prev_busy = m_busy;
        end
        prev_pend_d = (d_read_req | d_write_req) & ~d_valid;
        prev_pend_i = if_req & ~if_valid;
        prev_dwr    = d_write_req;
        prev_daddr  = d_addr;
        prev_dwdata = d_wdata;
        prev_iaddr  = if_addr;
      end
    end

    // Driver: two pipeline-style requesters that hold their request until their valid.
    logic [15:0] if_scr [$];
    d_item_t     d_scr [$];
    d_item_t     cur;
    logic [15:0] if_real;
    logic        d_act, rnd, drv_busy;
    int          cyc;

    initial begin
      reset_n = 1'b1;
      if_req = 1'b0; d_read_req = 1'b0; d_write_req = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      d_act = 1'b0; rnd = 1'b0; if_real = '0; cur = '0;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b1;

      for (int ph = 0; ph < 6; ph++) begin
        rnd = (ph == 5);
        case (ph)
          0: if_scr.push_back(16'h0010);
          1: begin
            if_scr.push_back(16'h0020);
            d_scr.push_back('{2'd0, 16'h0080, 16'h0000});
          end
          2: d_scr.push_back('{2'd1, 16'h0040, 16'hBEEF});
          3: begin
            if_scr.push_back(16'h0000);
            if_scr.push_back(16'h0001);
          end
          4: begin
            d_scr.push_back('{2'd2, 16'h00C0, 16'hA5A5});
            d_scr.push_back('{2'd0, 16'h00C0, 16'h0000});
          end
          default: begin
            for (int n = 0; n < 40; n++) begin
              if_scr.push_back({8'($urandom), 8'($urandom_range(0, 63))});
              d_scr.push_back('{2'($urandom_range(0, 2)),
                                {8'($urandom), 8'($urandom_range(64, 255))},
                                16'($urandom)});
            end
          end
        endcase
        cyc = 0;
        do begin
          @(posedge clk);
          #1;
          if (!if_req || if_valid) begin
            if (if_scr.size() != 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
              if_real = if_scr.pop_front();
              if_req  = 1'b1;
            end else if_req = 1'b0;
          end
          if (!d_act || d_valid) begin
            if (d_scr.size() != 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
              cur   = d_scr.pop_front();
              d_act = 1'b1;
            end else d_act = 1'b0;
          end
          // While the port is busy no grant can happen, so scramble the address/data inputs.
          drv_busy    = mem_readM | mem_writeM;
          if_addr     = (if_req && !drv_busy) ? if_real : 16'($urandom);
          d_read_req  = d_act && (cur.kind != 2'd1);
          d_write_req = d_act && (cur.kind != 2'd0);
          d_addr      = (d_act && !drv_busy) ? cur.addr : 16'($urandom);
          d_wdata     = (d_act && !drv_busy) ? cur.wdata : 16'($urandom);
          cyc++;
        end while ((if_scr.size() != 0 || d_scr.size() != 0 || if_req || d_act) && cyc < 4000);
        if (cyc >= 4000) fail_now(LAT, "phase_timeout");
      end

      // Reset one cycle into a load; the held load must be re-run with full latency.
      d_read_req = 1'b1; d_write_req = 1'b0; d_addr = 16'h0090; d_wdata = '0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      check(LAT, "async_rst_readM", 16'(mem_readM), 16'h0);
      check(LAT, "async_rst_writeM", 16'(mem_writeM), 16'h0);
      check(LAT, "async_rst_addr", mem_address, 16'h0);
      check(LAT, "async_rst_wdata", mem_wdata, 16'h0);
      check(LAT, "async_rst_if_data", if_data, 16'h0);
      check(LAT, "async_rst_d_rdata", d_rdata, 16'h0);
      check(LAT, "async_rst_valids", 16'({if_valid, d_valid}), 16'h0);
      @(negedge clk);
      #2 reset_n = 1'b1;
      cyc = 0;
      while (!d_valid && cyc < 40) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      if (!d_valid) fail_now(LAT, "regrant_timeout");
      d_read_req = 1'b0;
      repeat (3) @(posedge clk);
      done = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 60000; i++) begin
      @(posedge clk);
      if (u[0].done && u[1].done) break;
    end
    if (!(u[0].done && u[1].done)) fail_now(0, "global_timeout");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
